id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection. Captures decoded
//  control and operand data from ID and drives the EX stage, including ALUSrc/dataRt/signExt
//  for the EX operand-B mux. Inserts bubbles on load-use hazards and branch flushes.
//  Freezes on an external hold.
// PARAMETERS
//  DATA_W   32  width of the datapath: PC+4, register data, sign-extended immediate
//  REG_AW   5   register-index width
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       synchronous, active-high reset
//  hold          in   1       global freeze (memory stall); ID/EX holds its contents
//  flush         in   1       branch taken; next ID/EX content is a bubble
//  id_ctrl       in   9       {RegWrite,MemtoReg,MemRead,MemWrite,Branch,ALUSrc,ALUOp[1:0],RegDst}
//  id_uses_rt    in   1       ID instruction reads rt as a source
//  id_pc4        in   DATA_W  PC+4 of the ID instruction
//  id_dataRs     in   DATA_W  rs read data
//  id_dataRt     in   DATA_W  rt read data
//  id_signExt    in   DATA_W  sign-extended immediate
//  id_rs/id_rt/id_rd in REG_AW register indices
//  ex_ctrl       out  9       registered control, same bit order as id_ctrl
//  ex_ALUSrc     out  1       alias of ex_ctrl[3]
//  ex_valid      out  1       0 = bubble
//  ex_pc4/ex_dataRs/ex_dataRt/ex_signExt out DATA_W  registered data
//  ex_rs/ex_rt/ex_rd out REG_AW registered indices
//  pc_write      out  1       0 = PC must not advance (combinational)
//  ifid_write    out  1       0 = IF/ID must hold (combinational)
//  hazard        out  1       load-use stall detected this cycle (combinational)
// BEHAVIOUR
//  - Reset: all registered outputs are 0, including ex_valid and ex_ctrl.
//  - Latency: 1 cycle from ID to EX.
//  - hazard = ex_valid & ex_ctrl.MemRead & (ex_rt!=0) &
//      (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//  - pc_write = ifid_write = ~(hazard | hold).
//  - Per-edge update, in priority order:
//    reset > hold (keep all) > flush (bubble) > hazard (bubble) > load ID fields, ex_valid=1.
//  - Bubble: ex_ctrl=0 and ex_valid=0. Data and index fields still load from ID; their values
//    don't-care downstream, but the bench checks only ctrl and valid.
//  - A hazard lasts exactly 1 cycle: the bubble clears ex_ctrl.MemRead on the next edge.
//  - Simultaneous hold and hazard: hold wins. The hazard stays asserted, the register is
//    frozen, and the bubble is inserted on the first edge after hold drops.
//  - Flush together with hazard: bubble, and pc_write stays 0 for that cycle.
//  - Reset mid-stall: the register clears, so hazard deasserts in the next cycle.
//  - No arithmetic. Fields pass through bit-exact with no width conversion.
// CONFIGURATION
//  IDEX_STATS_EN defined:
//   - adds outputs bubble_cnt[31:0] and hold_cnt[31:0].
//   - bubble_cnt increments on each edge that loads a bubble (flush or hazard, not hold).
//   - hold_cnt increments on each edge with hold=1.
//   - Both counters clear on reset and wrap at 2^32-1 -> 0.
//  IDEX_STATS_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.
// STRUCTURE
//  - Shared package pipeline_pkg:
//    - CTRL_W=9 and bit-position constants for each control bit.
//    - ALUOp encodings: 00 add, 01 sub, 10 R-type.
//    - REG_ZERO index.
//  - Sub-module load_use_hazard is purely combinational. It takes ex_MemRead, ex_valid,
//    ex_rt, id_rs, id_rt and id_uses_rt, and outputs hazard.
//  - id_ex_stage contains the register, the priority logic and the optional counters.
// TESTING
//  1. Reset with non-zero ID inputs -> all ex_* outputs = 0 and pc_write=1 in the cycle
//     after reset drops.
//  2. Plain flow: id_ctrl=9'h1A4, id_dataRt=32'hDEADBEEF, id_signExt=32'hFFFF_FFF0 ->
//     the next cycle shows the same values, ex_valid=1 and ex_ALUSrc=ex_ctrl[3].
//  3. Load-use: EX holds lw with ex_rt=5; ID has id_rs=5 -> hazard=1, pc_write=0,
//     ifid_write=0; the next cycle has ex_valid=0 and ex_ctrl=0, then the ID instruction
//     loads; bubble_cnt=1.
//  4. No false hazard: ex_rt=0 with MemRead, id_rs=0 -> hazard=0. Also ex_rt=7,
//     id_rt=7, id_uses_rt=0 -> hazard=0.
//  5. Hold for 3 cycles during a hazard -> outputs frozen, hold_cnt=3. The bubble is
//     inserted on the edge after hold drops.
//  6. flush=1 with valid ID input -> the next cycle has ex_valid=0 and ex_ctrl=0.
//     Reset asserted mid-hold -> everything clears on the next edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-word layout, ALUOp encodings and the
// hard-wired zero register index used by the ID/EX stage and its hazard logic.
package pipeline_pkg;

  // Width of the decoded control word travelling down the pipeline
  localparam int CTRL_W = 9;

  // Bit positions inside {RegWrite,MemtoReg,MemRead,MemWrite,Branch,ALUSrc,ALUOp[1:0],RegDst}
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_REGDST   = 0;

  // ALUOp field encodings
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10
  } aluop_e;

  // Register 0 is hard-wired to zero and never creates a dependency
  localparam int REG_ZERO = 0;

  // Control word of a bubble: nothing written, nothing read, nothing branched
  function automatic logic [CTRL_W-1:0] bubble_ctrl();
    return '0;
  endfunction

endpackage

// File: rtl/load_use_hazard.sv
// Load-use hazard detector. Flags the case where the instruction in EX is a
// valid load whose destination rt is a non-zero register that the instruction
// currently in ID reads (rs always, rt only when it is a real source).
module load_use_hazard
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_MemRead,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              hazard
);

  logic ex_is_load;
  logic rt_nonzero;
  logic rs_match;
  logic rt_match;

  assign ex_is_load = ex_valid & ex_MemRead;
  assign rt_nonzero = (ex_rt != REG_AW'(REG_ZERO));
  assign rs_match   = (ex_rt == id_rs);
  assign rt_match   = id_uses_rt & (ex_rt == id_rt);

  // Stall request: load in EX feeds a source operand of the instruction in ID
  always_comb begin
    hazard = ex_is_load & rt_nonzero & (rs_match | rt_match);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with integrated load-use hazard detection.
// Captures decoded control and operands from ID and presents them to EX.
// Update priority on each clock edge:
//   reset > hold (freeze) > flush (bubble) > hazard (bubble) > load from ID.
// A bubble clears the control word and valid; the data/index fields still
// load from ID because nothing downstream looks at them in a bubble.
// Optional feature: define IDEX_STATS_EN to add bubble_cnt / hold_cnt
// statistics outputs (32-bit, wrapping, cleared on reset).
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_dataRs,
  input  logic [DATA_W-1:0] id_dataRt,
  input  logic [DATA_W-1:0] id_signExt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_ALUSrc,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_dataRs,
  output logic [DATA_W-1:0] ex_dataRt,
  output logic [DATA_W-1:0] ex_signExt,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              hazard
`ifdef IDEX_STATS_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       hold_cnt
`endif
);

  // EX-side register contents (stage p1 = one cycle after ID)
  logic [CTRL_W-1:0] ctrl_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] pc4_p1;
  logic [DATA_W-1:0] data_rs_p1;
  logic [DATA_W-1:0] data_rt_p1;
  logic [DATA_W-1:0] sign_ext_p1;
  logic [REG_AW-1:0] rs_p1;
  logic [REG_AW-1:0] rt_p1;
  logic [REG_AW-1:0] rd_p1;

  logic hazard_p0;
  logic insert_bubble;
  logic advance;

  load_use_hazard #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .ex_MemRead (ctrl_p1[CTRL_MEMREAD]),
    .ex_valid   (vld_p1),
    .ex_rt      (rt_p1),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .hazard     (hazard_p0)
  );

  // Hold freezes everything; otherwise flush or a load-use stall turn the
  // incoming instruction into a bubble.
  assign advance       = ~hold;
  assign insert_bubble = flush | hazard_p0;

  // Front-end stall: PC and IF/ID stop while a stall or a freeze is pending.
  // Flush does not stall the front end, but a coincident hazard still does.
  assign hazard     = hazard_p0;
  assign pc_write   = ~(hazard_p0 | hold);
  assign ifid_write = ~(hazard_p0 | hold);

  // ---- p0 -> p1 boundary: control word and valid ----
  // Control/valid register with bubble insertion
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (advance) begin
      if (insert_bubble) begin
        ctrl_p1 <= bubble_ctrl();
        vld_p1  <= 1'b0;
      end else begin
        ctrl_p1 <= id_ctrl;
        vld_p1  <= 1'b1;
      end
    end
  end

  // Data and index register: bit-exact pass-through, loads whenever not frozen
  always_ff @(posedge clk) begin
    if (reset) begin
      pc4_p1      <= '0;
      data_rs_p1  <= '0;
      data_rt_p1  <= '0;
      sign_ext_p1 <= '0;
      rs_p1       <= '0;
      rt_p1       <= '0;
      rd_p1       <= '0;
    end else if (advance) begin
      pc4_p1      <= id_pc4;
      data_rs_p1  <= id_dataRs;
      data_rt_p1  <= id_dataRt;
      sign_ext_p1 <= id_signExt;
      rs_p1       <= id_rs;
      rt_p1       <= id_rt;
      rd_p1       <= id_rd;
    end
  end

  assign ex_ctrl    = ctrl_p1;
  assign ex_ALUSrc  = ctrl_p1[CTRL_ALUSRC];
  assign ex_valid   = vld_p1;
  assign ex_pc4     = pc4_p1;
  assign ex_dataRs  = data_rs_p1;
  assign ex_dataRt  = data_rt_p1;
  assign ex_signExt = sign_ext_p1;
  assign ex_rs      = rs_p1;
  assign ex_rt      = rt_p1;
  assign ex_rd      = rd_p1;

`ifdef IDEX_STATS_EN
  logic [31:0] bubble_cnt_q;
  logic [31:0] hold_cnt_q;

  // Statistics: bubbles loaded (not frozen cycles) and frozen cycles; both wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      if (hold) begin
        hold_cnt_q <= hold_cnt_q + 32'd1;
      end else if (insert_bubble) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign hold_cnt   = hold_cnt_q;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stage.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int MEMREAD_BIT = 6;
  localparam int ALUSRC_BIT  = 3;

  logic              clk;
  logic              reset;
  logic              hold;
  logic              flush;
  logic [8:0]        id_ctrl;
  logic              id_uses_rt;
  logic [DATA_W-1:0] id_pc4, id_dataRs, id_dataRt, id_signExt;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [8:0]        ex_ctrl;
  logic              ex_ALUSrc, ex_valid;
  logic [DATA_W-1:0] ex_pc4, ex_dataRs, ex_dataRt, ex_signExt;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic              pc_write, ifid_write, hazard;
`ifdef IDEX_STATS_EN
  logic [31:0]       bubble_cnt, hold_cnt;
`endif

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .flush      (flush),
    .id_ctrl    (id_ctrl),
    .id_uses_rt (id_uses_rt),
    .id_pc4     (id_pc4),
    .id_dataRs  (id_dataRs),
    .id_dataRt  (id_dataRt),
    .id_signExt (id_signExt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .ex_ctrl    (ex_ctrl),
    .ex_ALUSrc  (ex_ALUSrc),
    .ex_valid   (ex_valid),
    .ex_pc4     (ex_pc4),
    .ex_dataRs  (ex_dataRs),
    .ex_dataRt  (ex_dataRt),
    .ex_signExt (ex_signExt),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_rd      (ex_rd),
    .pc_write   (pc_write),
    .ifid_write (ifid_write),
    .hazard     (hazard)
`ifdef IDEX_STATS_EN
    ,
    .bubble_cnt (bubble_cnt),
    .hold_cnt   (hold_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model of what instruction sits in EX
  typedef struct {
    bit          valid;
    bit [8:0]    ctrl;
    bit [31:0]   pc4, drs, drt, sext;
    bit [4:0]    rs, rt, rd;
  } ex_slot_t;

  ex_slot_t    m;
  bit          m_data_known;
  longint      m_bubbles;
  longint      m_holds;
  bit          exp_haz;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Does the load in EX feed a source of the instruction in ID?
  function automatic bit load_use(input ex_slot_t s, input bit [4:0] rs, input bit [4:0] rt, input bit uses_rt);
    if (!s.valid || !s.ctrl[MEMREAD_BIT] || s.rt == 5'd0) return 1'b0;
    return (s.rt == rs) || (uses_rt && s.rt == rt);
  endfunction

  task automatic set_id(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic ur);
    id_ctrl    = c;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_uses_rt = ur;
    id_pc4     = $urandom;
    id_dataRs  = $urandom;
    id_dataRt  = $urandom;
    id_signExt = $urandom;
  endtask

  // One cycle: check combinational outputs, clock, advance model, check registers
  task automatic step(input string tag);
    #1;
    exp_haz = load_use(m, id_rs, id_rt, id_uses_rt);
    check({tag, ".hazard"}, hazard, exp_haz);
    check({tag, ".pc_write"}, pc_write, !(exp_haz || hold));
    check({tag, ".ifid_write"}, ifid_write, !(exp_haz || hold));
    @(posedge clk);
    if (reset) begin
      m = '{default: '0};
      m_data_known = 1'b1;
      m_bubbles = 0;
      m_holds = 0;
    end else if (hold) begin
      m_holds++;
    end else begin
      m.valid = !(flush || exp_haz);
      m.ctrl  = m.valid ? id_ctrl : 9'd0;
      m.pc4 = id_pc4; m.drs = id_dataRs; m.drt = id_dataRt; m.sext = id_signExt;
      m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
      m_data_known = m.valid;
      if (!m.valid) m_bubbles++;
    end
    #1;
    check({tag, ".ex_valid"}, ex_valid, m.valid);
    check({tag, ".ex_ctrl"}, ex_ctrl, m.ctrl);
    check({tag, ".ex_ALUSrc"}, ex_ALUSrc, m.ctrl[ALUSRC_BIT]);
    if (m_data_known) begin
      check({tag, ".ex_pc4"}, ex_pc4, m.pc4);
      check({tag, ".ex_dataRs"}, ex_dataRs, m.drs);
      check({tag, ".ex_dataRt"}, ex_dataRt, m.drt);
      check({tag, ".ex_signExt"}, ex_signExt, m.sext);
      check({tag, ".ex_idx"}, {ex_rs, ex_rt, ex_rd}, {m.rs, m.rt, m.rd});
    end
`ifdef IDEX_STATS_EN
    check({tag, ".bubble_cnt"}, bubble_cnt, m_bubbles[31:0]);
    check({tag, ".hold_cnt"}, hold_cnt, m_holds[31:0]);
`endif
    @(negedge clk);
  endtask

  localparam logic [8:0] LW_CTRL = 9'h1C8;  // RegWrite, MemtoReg, MemRead, ALUSrc
  localparam logic [8:0] R_CTRL  = 9'h105;  // RegWrite, ALUOp=R-type, RegDst

  initial begin
    m = '{default: '0};
    m_data_known = 1'b0;
    m_bubbles = 0;
    m_holds = 0;
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    set_id(9'h1FF, 5'd3, 5'd4, 5'd5, 1'b1);
    @(negedge clk);

    // 1. reset with non-zero ID inputs
    step("rst0");
    step("rst1");
    reset = 1'b0;

    // 2. plain flow
    set_id(9'h1A4, 5'd1, 5'd2, 5'd3, 1'b1);
    id_dataRt  = 32'hDEADBEEF;
    id_signExt = 32'hFFFF_FFF0;
    step("flow");
    check("flow.dataRt_const", ex_dataRt, 32'hDEADBEEF);
    check("flow.signExt_const", ex_signExt, 32'hFFFF_FFF0);

    // 3. load-use on rs
    set_id(LW_CTRL, 5'd2, 5'd5, 5'd0, 1'b0);
    step("lu_lw");
    set_id(R_CTRL, 5'd5, 5'd6, 5'd7, 1'b1);
    step("lu_stall");
    step("lu_retry");

    // 4. no false hazards, plus rt-source positive case
    set_id(LW_CTRL, 5'd1, 5'd0, 5'd0, 1'b0);
    step("z_lw");
    set_id(R_CTRL, 5'd0, 5'd0, 5'd8, 1'b1);
    step("z_use");
    set_id(LW_CTRL, 5'd1, 5'd7, 5'd0, 1'b0);
    step("nrt_lw");
    set_id(9'h0C8, 5'd2, 5'd7, 5'd9, 1'b0);
    step("nrt_use");
    set_id(LW_CTRL, 5'd1, 5'd7, 5'd0, 1'b0);
    step("rt_lw");
    set_id(R_CTRL, 5'd2, 5'd7, 5'd9, 1'b1);
    step("rt_use");
    step("rt_retry");

    // 5. hold for 3 cycles during a hazard
    set_id(LW_CTRL, 5'd1, 5'd9, 5'd0, 1'b0);
    step("hh_lw");
    set_id(R_CTRL, 5'd9, 5'd3, 5'd4, 1'b1);
    hold = 1'b1;
    step("hh_h1");
    step("hh_h2");
    step("hh_h3");
    hold = 1'b0;
    step("hh_bubble");
    step("hh_retry");

    // 6. flush, flush with hazard, reset mid-hold
    set_id(R_CTRL, 5'd1, 5'd2, 5'd3, 1'b1);
    flush = 1'b1;
    step("flush");
    flush = 1'b0;
    set_id(LW_CTRL, 5'd1, 5'd10, 5'd0, 1'b0);
    step("fh_lw");
    set_id(R_CTRL, 5'd10, 5'd2, 5'd3, 1'b1);
    flush = 1'b1;
    step("fh_both");
    flush = 1'b0;
    set_id(LW_CTRL, 5'd1, 5'd11, 5'd0, 1'b0);
    step("rh_lw");
    set_id(R_CTRL, 5'd11, 5'd2, 5'd3, 1'b1);
    hold = 1'b1;
    step("rh_hold");
    reset = 1'b1;
    step("rh_reset");
    reset = 1'b0;
    hold = 1'b0;
    step("rh_after");

    // Random traffic: small register range makes dependencies frequent
    for (int i = 0; i < 400; i++) begin
      set_id(9'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 31)), 1'($urandom));
      if ($urandom_range(0, 2) == 0) id_ctrl[MEMREAD_BIT] = 1'b1;
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 63) == 0);
      step("rnd");
    end
    reset = 1'b0; hold = 1'b0; flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
